bht: RTL
========

BHT -- requirements
Module: bht

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 9, set-index width; SETS = 2**INDEX_WIDTH (512).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bht_ready  output  1  high once the init sweep completes.
REQ-005 SHALL have port bpu_bht_read_enable  input  1  prediction lookup request.
REQ-006 SHALL have port bpu_bht_read_index  input  INDEX_WIDTH  set to read (pc[12:4]).
REQ-007 SHALL have port bht_read_valid  output  1  read data valid (registered).
REQ-008 SHALL have port bht_read_counters  output  8  four 2-bit counters; slot k at bits [2k+1:2k].
REQ-009 SHALL have port bht_read_taken  output  4  MSB of each counter.
REQ-010 SHALL have port bht_read_hit  output  1  set valid bit.
REQ-011 SHALL have port bjusb_bht_write_enable  input  1  update request from the BJU.
REQ-012 SHALL have port bjusb_bht_write_index  input  INDEX_WIDTH  set to update.
REQ-013 SHALL have port bjusb_bht_write_counter_select  input  2  slot within set (pc[3:2]).
REQ-014 SHALL have port bjusb_bht_write_inc  input  1  increment selected counter.
REQ-015 SHALL have port bjusb_bht_write_dec  input  1  decrement selected counter.
REQ-016 SHALL have port bjusb_bht_valid_in  input  1  value written to the set valid bit.

Function
REQ-017 SHALL store per set: one valid bit and four 2-bit saturating counters, in flops.
REQ-018 SHALL implement FSM INIT -> READY; INIT walks init_idx 0..SETS-1, one set per cycle, writing counters=2'b01 and valid=0.
REQ-019 SHALL go to READY the cycle after init_idx == SETS-1 is written; bht_ready=1 from then on (SETS cycles after reset release).
REQ-020 SHALL ignore read and write requests during INIT; bht_read_valid stays 0.
REQ-021 SHALL return a read with one-cycle latency: enable at cycle N -> valid, counters, taken, hit at N+1; bht_read_valid=0 in cycles without a request.
REQ-022 SHALL hold read data outputs when no read occurs; only bht_read_valid drops.
REQ-023 SHALL, on write_enable in READY, update the selected counter: inc only -> +1 saturating at 2'b11; dec only -> -1 saturating at 2'b00; both or neither -> unchanged.
REQ-024 SHALL set the written set's valid bit to bjusb_bht_valid_in; other slots in the set are unchanged.
REQ-025 SHALL resolve a same-cycle read and write to the same index per REQ-029/030; different indices are independent.
REQ-026 SHALL treat back-to-back writes to the same counter as cumulative (each sees the prior cycle's result).

Reset
REQ-027 SHALL, on reset assertion, immediately force FSM=INIT, init_idx=0, bht_ready=0, bht_read_valid=0, bht_read_counters=0, bht_read_taken=0, bht_read_hit=0.
REQ-028 SHALL restart the init sweep from set 0 when reset asserts mid-sweep or mid-operation.

Configuration
REQ-029 SHALL, with BHT_BYPASS_EN defined, return the post-update counters and valid bit on a same-index same-cycle read/write.
REQ-030 SHALL, without BHT_BYPASS_EN, return the pre-update values in that case; the update still commits.

Structure
REQ-031 SHALL take BHT_WAYS=4, BHT_CTR_WIDTH=2 and BHT_CTR_INIT=2'b01 from the shared package.
REQ-032 SHALL instantiate sub-module bht_sat_ctr (combinational 2-bit inc/dec saturate) for the write datapath.

Verification
REQ-033 SHALL cover: reset release -> bht_ready=0 for 512 cycles, 1 at cycle 512; a read of set 5 returns counters=8'h55, hit=0.
REQ-034 SHALL cover: write set 3, slot 2, inc x3, valid_in=1 -> read set 3 gives counters=8'h75, taken=4'b0100, hit=1.
REQ-035 SHALL cover: dec x4 on slot 0 of a fresh set -> counter saturates at 0; inc+dec together -> unchanged.
REQ-036 SHALL cover: same-cycle read/write of set 9, slot 1, inc -> next cycle counters=8'h59 with BHT_BYPASS_EN, 8'h55 without.
REQ-037 SHALL cover: reset pulse at sweep cycle 200 -> bht_ready low, sweep restarts, ready 512 cycles after release.
REQ-038 SHALL cover: write during INIT at index 600 mod SETS -> no effect; post-init read shows 8'h55.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared BHT geometry, counter encoding and FSM state type.
// Optional same-cycle read/write forwarding is enabled by defining BHT_BYPASS_EN.
package bht_pkg;
  localparam int BHT_WAYS      = 4;
  localparam int BHT_CTR_WIDTH = 2;
  localparam int BHT_SET_WIDTH = BHT_WAYS * BHT_CTR_WIDTH;

  typedef logic [BHT_CTR_WIDTH-1:0] bht_ctr_t;
  typedef logic [BHT_SET_WIDTH-1:0] bht_set_t;

  localparam bht_ctr_t BHT_CTR_INIT = 2'b01;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bht_state_e;

  function automatic bht_set_t bht_set_init();
    return {BHT_WAYS{BHT_CTR_INIT}};
  endfunction
endpackage

// File: rtl/bht_sat_ctr.sv
// Combinational 2-bit saturating counter step; inc and dec together cancel.
module bht_sat_ctr
  import bht_pkg::*;
(
  input  bht_ctr_t ctr,
  input  logic     inc,
  input  logic     dec,
  output bht_ctr_t ctr_next
);
  always_comb begin
    ctr_next = ctr;
    if (inc && !dec && (ctr != '1)) begin
      ctr_next = ctr + bht_ctr_t'(1);
    end else if (dec && !inc && (ctr != '0)) begin
      ctr_next = ctr - bht_ctr_t'(1);
    end
  end
endmodule

// File: rtl/bht.sv
// Branch history table: per-set valid bit plus four 2-bit counters, swept to
// weakly-not-taken after reset. BHT_BYPASS_EN forwards same-index writes to reads.
module bht
  import bht_pkg::*;
#(
  parameter int INDEX_WIDTH = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   bht_ready,
  input  logic                   bpu_bht_read_enable,
  input  logic [INDEX_WIDTH-1:0] bpu_bht_read_index,
  output logic                   bht_read_valid,
  output logic [7:0]             bht_read_counters,
  output logic [3:0]             bht_read_taken,
  output logic                   bht_read_hit,
  input  logic                   bjusb_bht_write_enable,
  input  logic [INDEX_WIDTH-1:0] bjusb_bht_write_index,
  input  logic [1:0]             bjusb_bht_write_counter_select,
  input  logic                   bjusb_bht_write_inc,
  input  logic                   bjusb_bht_write_dec,
  input  logic                   bjusb_bht_valid_in,
  output bht_state_e             bht_state
);
  localparam int SETS = 1 << INDEX_WIDTH;

  // Handshake: requests are single-cycle strobes with no backpressure; a read
  // accepted while bht_ready=1 yields bht_read_valid=1 exactly one cycle later.
  bht_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_idx;
  logic                   init_we, init_last, rd_fire, wr_fire;

  bht_set_t               ctr_mem [SETS];
  logic [SETS-1:0]        valid_mem;

  bht_set_t               wr_old_set, wr_new_set, rd_set;
  bht_ctr_t               wr_old_ctr, wr_new_ctr;
  logic                   rd_hit;

  assign init_last = (init_idx == INDEX_WIDTH'(SETS - 1));
  assign bht_state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_last) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_we   = (state_q == ST_INIT);
    bht_ready = (state_q == ST_READY);
    rd_fire   = bht_ready && bpu_bht_read_enable;
    wr_fire   = bht_ready && bjusb_bht_write_enable;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        init_idx <= '0;
    else if (init_we) init_idx <= init_idx + INDEX_WIDTH'(1);
  end

  // Read-modify-write of the selected slot; the other slots pass through.
  always_comb begin
    wr_old_set = ctr_mem[bjusb_bht_write_index];
    wr_old_ctr = '0;
    for (int k = 0; k < BHT_WAYS; k++) begin
      if (bjusb_bht_write_counter_select == 2'(k))
        wr_old_ctr = wr_old_set[k*BHT_CTR_WIDTH +: BHT_CTR_WIDTH];
    end
  end

  bht_sat_ctr u_sat_ctr (
    .ctr      (wr_old_ctr),
    .inc      (bjusb_bht_write_inc),
    .dec      (bjusb_bht_write_dec),
    .ctr_next (wr_new_ctr)
  );

  always_comb begin
    wr_new_set = wr_old_set;
    for (int k = 0; k < BHT_WAYS; k++) begin
      if (bjusb_bht_write_counter_select == 2'(k))
        wr_new_set[k*BHT_CTR_WIDTH +: BHT_CTR_WIDTH] = wr_new_ctr;
    end
  end

  // Storage is not reset; the init sweep establishes its contents.
  always_ff @(posedge clock) begin
    if (init_we) begin
      ctr_mem[init_idx]   <= bht_set_init();
      valid_mem[init_idx] <= 1'b0;
    end else if (wr_fire) begin
      ctr_mem[bjusb_bht_write_index]   <= wr_new_set;
      valid_mem[bjusb_bht_write_index] <= bjusb_bht_valid_in;
    end
  end

  always_comb begin
`ifdef BHT_BYPASS_EN
    if (wr_fire && (bjusb_bht_write_index == bpu_bht_read_index)) begin
      rd_set = wr_new_set;
      rd_hit = bjusb_bht_valid_in;
    end else begin
      rd_set = ctr_mem[bpu_bht_read_index];
      rd_hit = valid_mem[bpu_bht_read_index];
    end
`else
    rd_set = ctr_mem[bpu_bht_read_index];
    rd_hit = valid_mem[bpu_bht_read_index];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bht_read_valid    <= 1'b0;
      bht_read_counters <= '0;
      bht_read_hit      <= 1'b0;
    end else begin
      bht_read_valid <= rd_fire;
      if (rd_fire) begin
        bht_read_counters <= rd_set;
        bht_read_hit      <= rd_hit;
      end
    end
  end

  always_comb begin
    bht_read_taken = '0;
    for (int k = 0; k < BHT_WAYS; k++)
      bht_read_taken[k] = bht_read_counters[k*BHT_CTR_WIDTH + BHT_CTR_WIDTH - 1];
  end
endmodule
